itwiddle_stream: RTL and testbench
==================================

// Module: itwiddle_stream
// PURPOSE
//  Streaming inverse twiddle rotator for the 16-point IFFT path: multiplies each sample of a
//  4x4-decomposed frame by conj(W16^e), e = idx[3:2]*idx[1:0], i.e. W16^-e.
//  One complex sample per beat, valid/ready in and out, 3-stage pipeline.
//  Sits between the first and second radix-4 stages of the IFFT datapath.
// PARAMETERS
//  DW    16  sample width per component, two's complement, Q2.14 (1.0 = 16384)
//  FRAME 16  samples per frame; fixed, index counter is 4 bits
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  s_valid    in   1   input beat valid
//  s_ready    out  1   input beat accepted when s_valid && s_ready
//  s_re/s_im  in   DW  input sample, real/imag
//  s_last     in   1   marks the final beat of a frame
//  m_valid    out  1   output beat valid
//  m_ready    in   1   downstream accepts
//  m_re/m_im  out  DW  rotated sample
//  m_last     out  1   end of frame; set on output beat with idx 15
//  m_idx      out  4   frame position of output beat
//  m_sat      out  1   this beat saturated in re or im
//  frame_err  out  1   one-cycle pulse: s_last accepted at idx != 15
// BEHAVIOUR
//  Reset: all outputs 0, except s_ready = 1. Index counter = 0, pipeline empty.
//  Pipeline enable en = m_ready || !m_valid; s_ready = en. Stall freezes all 3 stages.
//  Latency 3 accepted cycles; with m_ready held high: 1 beat/clock, no bubbles inserted.
//  Index counter increments on each accepted beat, wraps 15->0.
//  s_last at idx 15: normal. s_last at idx < 15: pulse frame_err, counter forced to 0.
//  idx 15 without s_last: no error, counter wraps; m_last follows idx==15.
//  Twiddle ROM (conj, Q2.14, re,im) by exponent e:
//   e0:(16384,0)  e1:(15137,6270)  e2:(11585,11585)  e3:(6270,15137)
//   e4:(0,16384)  e6:(-11585,11585)  e9:(-15137,-6270)
//  Stage 1: register sample, idx, last; look up (wr,wi). Stage 2: four signed 32-bit products.
//  Stage 3: re = xr*wr - xi*wi, im = xr*wi + xi*wr in 34 bits; add 2^13; arithmetic >>14.
//   Saturate to [-32768, 32767]; m_sat = 1 if either component clipped.
//  e0 path passes through the same multiply; result exact (x*16384>>14 = x).
//  Reset mid-frame: in-flight beats are discarded. The next accepted beat is idx 0.
// STRUCTURE
//  Shared package fft_pkg: DW, Q frac bits (14), twiddle ROM constants, exponent function.
//  Sub-module cmul_q14_pipe: 2-stage signed complex multiply with round/saturate and enable.
//   Top holds the input stage, index counter, ROM, last/err logic, and handshake.
// TESTING
//  idx 5 beat (16384,0) -> m_re=15137, m_im=6270, m_sat=0, 3 cycles after accept.
//  idx 10 beat (1000,0) -> (0,1000); idx 0..4 beats pass unchanged bit-exact.
//  idx 6 beat (32767,32767) -> m_re=0, m_im=32767, m_sat=1.
//  16 back-to-back beats, m_ready low 5 cycles mid-frame -> outputs held stable.
//   No loss or duplication; m_last only on idx 15.
//  s_last at idx 7 -> frame_err pulse 1 cycle; next accepted beat has m_idx=0.
//  rst_n low at idx 9 mid-stream -> m_valid=0 immediately; s_ready=1.
//   Next frame starts at idx 0 with correct twiddles.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared fixed-point definitions for the IFFT datapath: Q2.14 samples, inverse twiddle ROM,
// exponent mapping for the 4x4 decomposition, and the output saturation helper.
package fft_pkg;

  localparam int unsigned DW       = 16;
  localparam int unsigned QBits    = 14;
  localparam int unsigned FrameLen = 16;
  localparam logic [3:0]  LastIdx  = 4'd15;

  typedef logic signed [DW-1:0] sampleT;

  typedef struct packed {
    sampleT re;
    sampleT im;
  } cplxT;

  // e = row * col of the 4x4 index split; only 0,1,2,3,4,6,9 can occur
  function automatic logic [3:0] twExp(input logic [3:0] idx);
    return {2'b00, idx[3:2]} * {2'b00, idx[1:0]};
  endfunction

  // Stored already conjugated, so the rotator always does a plain complex multiply
  function automatic cplxT twiddle(input logic [3:0] e);
    unique case (e)
      4'd1:    return '{re: 16'sd15137,  im: 16'sd6270};
      4'd2:    return '{re: 16'sd11585,  im: 16'sd11585};
      4'd3:    return '{re: 16'sd6270,   im: 16'sd15137};
      4'd4:    return '{re: 16'sd0,      im: 16'sd16384};
      4'd6:    return '{re: -16'sd11585, im: 16'sd11585};
      4'd9:    return '{re: -16'sd15137, im: -16'sd6270};
      default: return '{re: 16'sd16384,  im: 16'sd0};
    endcase
  endfunction

  // Returns {clipped, value} after clamping to the signed DW-bit range
  function automatic logic [DW:0] satQ(input logic signed [19:0] v);
    if (v > 20'sd32767) begin
      return {1'b1, 16'h7fff};
    end else if (v < -20'sd32768) begin
      return {1'b1, 16'h8000};
    end else begin
      return {1'b0, v[DW-1:0]};
    end
  endfunction

endpackage

// File: rtl/itwiddle_stream_if.sv
// Input and output stream bundle of the inverse twiddle rotator.
// slave is the rotator's view; master is the surrounding datapath's view.
interface itwiddle_stream_if;

  logic                           s_valid;
  logic                           s_ready;
  logic signed [fft_pkg::DW-1:0]  s_re;
  logic signed [fft_pkg::DW-1:0]  s_im;
  logic                           s_last;

  logic                           m_valid;
  logic                           m_ready;
  logic signed [fft_pkg::DW-1:0]  m_re;
  logic signed [fft_pkg::DW-1:0]  m_im;
  logic                           m_last;
  logic [3:0]                     m_idx;
  logic                           m_sat;

  modport slave (
    input  s_valid, s_re, s_im, s_last, m_ready,
    output s_ready, m_valid, m_re, m_im, m_last, m_idx, m_sat
  );

  modport master (
    output s_valid, s_re, s_im, s_last, m_ready,
    input  s_ready, m_valid, m_re, m_im, m_last, m_idx, m_sat
  );

endinterface

// File: rtl/cmul_q14_pipe.sv
// Two-stage signed Q2.14 complex multiply: registered partial products, then
// sum, round-half-up, shift and saturate. A sideband tag travels alongside.
module cmul_q14_pipe
  import fft_pkg::*;
#(
  parameter int unsigned TagW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            inValid,
  input  cplxT            x,
  input  cplxT            w,
  input  logic [TagW-1:0] tagIn,
  output logic            outValid,
  output cplxT            y,
  output logic            sat,
  output logic [TagW-1:0] tagOut
);

  logic                  vA;
  logic signed [31:0]    pRR, pII, pRI, pIR;
  logic [TagW-1:0]       tagA;
  logic signed [33:0]    sumRe, sumIm;
  logic [DW:0]           satRe, satIm;

  always_comb begin
    sumRe = 34'(pRR) - 34'(pII) + 34'sd8192;
    sumIm = 34'(pRI) + 34'(pIR) + 34'sd8192;
    satRe = satQ(20'(sumRe >>> QBits));
    satIm = satQ(20'(sumIm >>> QBits));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vA       <= 1'b0;
      pRR      <= '0;
      pII      <= '0;
      pRI      <= '0;
      pIR      <= '0;
      tagA     <= '0;
      outValid <= 1'b0;
      y        <= '0;
      sat      <= 1'b0;
      tagOut   <= '0;
    end else if (en) begin
      vA       <= inValid;
      pRR      <= 32'(x.re) * 32'(w.re);
      pII      <= 32'(x.im) * 32'(w.im);
      pRI      <= 32'(x.re) * 32'(w.im);
      pIR      <= 32'(x.im) * 32'(w.re);
      tagA     <= tagIn;
      outValid <= vA;
      y        <= '{re: satRe[DW-1:0], im: satIm[DW-1:0]};
      sat      <= satRe[DW] | satIm[DW];
      tagOut   <= tagA;
    end
  end

endmodule

// File: rtl/itwiddle_stream.sv
// Streaming inverse twiddle rotator between the two radix-4 IFFT stages: each beat is
// multiplied by conj(W16^e) for its frame position, through a 3-stage stallable pipeline.
module itwiddle_stream
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  itwiddle_stream_if.slave bus,
  output logic             frame_err
);

  logic       en;
  logic       accept;
  logic       errPulse;
  logic [3:0] idxCnt;

  logic       v1;
  cplxT       x1;
  cplxT       w1;
  logic [3:0] idx1;

  logic       yValid;
  cplxT       y;
  logic       ySat;
  logic [4:0] tagOut;

  // Whole pipeline advances together; only a held output beat stalls it
  assign en          = bus.m_ready || !bus.m_valid;
  assign bus.s_ready = en;
  assign accept      = bus.s_valid && en;
  assign errPulse    = accept && bus.s_last && (idxCnt != LastIdx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idxCnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= errPulse;
      if (accept) begin
        idxCnt <= errPulse ? 4'd0 : idxCnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      x1   <= '0;
      w1   <= '0;
      idx1 <= '0;
    end else if (en) begin
      v1   <= bus.s_valid;
      x1   <= '{re: bus.s_re, im: bus.s_im};
      w1   <= twiddle(twExp(idxCnt));
      idx1 <= idxCnt;
    end
  end

  cmul_q14_pipe #(
    .TagW(5)
  ) u_cmul (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .inValid  (v1),
    .x        (x1),
    .w        (w1),
    .tagIn    ({idx1, idx1 == LastIdx}),
    .outValid (yValid),
    .y        (y),
    .sat      (ySat),
    .tagOut   (tagOut)
  );

  assign bus.m_valid = yValid;
  assign bus.m_re    = y.re;
  assign bus.m_im    = y.im;
  assign bus.m_sat   = ySat;
  assign bus.m_idx   = tagOut[4:1];
  assign bus.m_last  = tagOut[0];

endmodule

// File: tb/tb_itwiddle_stream.sv
// Directed bench for itwiddle_stream: reset state, per-index rotation, saturation,
// back-pressure, frame error recovery and mid-stream reset.
module tb_itwiddle_stream;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [3:0]  idx;
    logic        last;
    logic        sat;
  } beatT;

  logic clk;
  logic rst_n;
  logic frameErr;
  int   nAsserts;
  int   nFails;
  beatT outQ[$];

  itwiddle_stream_if bus ();

  itwiddle_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .frame_err (frameErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      outQ.push_back('{re: bus.m_re, im: bus.m_im, idx: bus.m_idx, last: bus.m_last,
                       sat: bus.m_sat});
    end
  end

  // Frame 1: hand-computed rotations per index
  int f1Xr[16]  = '{1234, -32768, 0, 100, -1, 16384, 32767, 16384, 5, 16384, 1000, 16384,
                    -32768, 0, 16384, 16384};
  int f1Xi[16]  = '{-567, 32767, 0, -100, 1, 0, 32767, 0, 7, 0, 0, 0, -32768, 16384, 16384, 0};
  int f1Er[16]  = '{1234, -32768, 0, 100, -1, 15137, 0, 6270, 5, 11585, 0, -11585, -32768,
                    -15137, -23170, -15137};
  int f1Ei[16]  = '{-567, 32767, 0, -100, 1, 6270, 32767, 15137, 7, 11585, 1000, 11585, -32768,
                    6270, 0, -6270};
  int f1Sat[16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input int idx, input int xr, input int xi,
                                output int er, output int ei, output bit s);
    int     e;
    int     wr;
    int     wi;
    longint r;
    longint m;
    e = (idx / 4) * (idx % 4);
    case (e)
      1:       begin wr = 15137;  wi = 6270;   end
      2:       begin wr = 11585;  wi = 11585;  end
      3:       begin wr = 6270;   wi = 15137;  end
      4:       begin wr = 0;      wi = 16384;  end
      6:       begin wr = -11585; wi = 11585;  end
      9:       begin wr = -15137; wi = -6270;  end
      default: begin wr = 16384;  wi = 0;      end
    endcase
    r = (longint'(xr) * wr - longint'(xi) * wi + 8192) >>> 14;
    m = (longint'(xr) * wi + longint'(xi) * wr + 8192) >>> 14;
    s = 1'b0;
    if (r > 32767)  begin r = 32767;  s = 1'b1; end
    if (r < -32768) begin r = -32768; s = 1'b1; end
    if (m > 32767)  begin m = 32767;  s = 1'b1; end
    if (m < -32768) begin m = -32768; s = 1'b1; end
    er = int'(r);
    ei = int'(m);
  endfunction

  task automatic sendOne(input int xr, input int xi, input logic last);
    int waitCnt;
    bus.s_valid = 1'b1;
    bus.s_re    = 16'(xr);
    bus.s_im    = 16'(xi);
    bus.s_last  = last;
    #1;
    waitCnt = 0;
    while (!bus.s_ready && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    if (waitCnt >= 20) chk("send_timeout", 16'(waitCnt), 16'd0);
    tick();
  endtask

  initial begin
    int er;
    int ei;
    bit es;
    int c;
    int i;
    logic acc;
    logic [15:0] holdRe;
    logic [15:0] holdIm;
    logic [3:0]  holdIdx;

    nAsserts    = 0;
    nFails      = 0;
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_re    = '0;
    bus.s_im    = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_m_valid", 16'(bus.m_valid), 16'd0);
    chk("rst_s_ready", 16'(bus.s_ready), 16'd1);
    chk("rst_m_re", bus.m_re, 16'd0);
    chk("rst_m_im", bus.m_im, 16'd0);
    chk("rst_m_idx", 16'(bus.m_idx), 16'd0);
    chk("rst_m_last", 16'(bus.m_last), 16'd0);
    chk("rst_m_sat", 16'(bus.m_sat), 16'd0);
    chk("rst_frame_err", 16'(frameErr), 16'd0);
    rst_n = 1'b1;
    tick();

    // Frame 1: back-to-back, output of beat k visible 3 edges after its accept edge
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc < 16) begin
        bus.s_valid = 1'b1;
        bus.s_re    = 16'(f1Xr[cyc]);
        bus.s_im    = 16'(f1Xi[cyc]);
        bus.s_last  = (cyc == 15);
      end else begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
      end
      tick();
      chk($sformatf("f1_valid_%0d", cyc), 16'(bus.m_valid), (cyc >= 2) ? 16'd1 : 16'd0);
      if (cyc >= 2) begin
        chk($sformatf("f1_re_%0d", cyc - 2), bus.m_re, 16'(f1Er[cyc-2]));
        chk($sformatf("f1_im_%0d", cyc - 2), bus.m_im, 16'(f1Ei[cyc-2]));
        chk($sformatf("f1_sat_%0d", cyc - 2), 16'(bus.m_sat), 16'(f1Sat[cyc-2]));
        chk($sformatf("f1_idx_%0d", cyc - 2), 16'(bus.m_idx), 16'(cyc - 2));
        chk($sformatf("f1_last_%0d", cyc - 2), 16'(bus.m_last), (cyc == 17) ? 16'd1 : 16'd0);
      end
    end
    repeat (3) tick();

    // Frame 2: back-pressure for 5 cycles mid-frame
    outQ.delete();
    c = 0;
    i = 0;
    holdRe = '0;
    holdIm = '0;
    holdIdx = '0;
    while (i < 16 && c < 60) begin
      bus.m_ready = !(c >= 6 && c < 11);
      bus.s_valid = 1'b1;
      bus.s_re    = 16'(i * 1000 - 7000);
      bus.s_im    = 16'(500 - i * 300);
      bus.s_last  = (i == 15);
      #1;
      if (c == 6) begin
        chk("f2_stall_valid", 16'(bus.m_valid), 16'd1);
        holdRe  = bus.m_re;
        holdIm  = bus.m_im;
        holdIdx = bus.m_idx;
      end else if (c > 6 && c < 11) begin
        chk($sformatf("f2_hold_re_%0d", c), bus.m_re, holdRe);
        chk($sformatf("f2_hold_im_%0d", c), bus.m_im, holdIm);
        chk($sformatf("f2_hold_idx_%0d", c), 16'(bus.m_idx), 16'(holdIdx));
      end
      acc = bus.s_ready;
      tick();
      if (acc) i++;
      c++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    repeat (6) tick();
    chk("f2_sent", 16'(i), 16'd16);
    chk("f2_count", 16'(outQ.size()), 16'd16);
    for (int k = 0; k < 16 && k < outQ.size(); k++) begin
      model(k, k * 1000 - 7000, 500 - k * 300, er, ei, es);
      chk($sformatf("f2_idx_%0d", k), 16'(outQ[k].idx), 16'(k));
      chk($sformatf("f2_re_%0d", k), outQ[k].re, 16'(er));
      chk($sformatf("f2_im_%0d", k), outQ[k].im, 16'(ei));
      chk($sformatf("f2_last_%0d", k), 16'(outQ[k].last), (k == 15) ? 16'd1 : 16'd0);
    end

    // Early s_last at idx 7
    outQ.delete();
    for (int k = 0; k < 8; k++) begin
      sendOne(k * 100, 0, k == 7);
      if (k == 6) chk("err_before", 16'(frameErr), 16'd0);
    end
    chk("err_pulse", 16'(frameErr), 16'd1);
    sendOne(16384, 0, 1'b0);
    chk("err_cleared", 16'(frameErr), 16'd0);
    bus.s_valid = 1'b0;
    repeat (5) tick();
    chk("err_count", 16'(outQ.size()), 16'd9);
    if (outQ.size() == 9) begin
      chk("err_idx7", 16'(outQ[7].idx), 16'd7);
      chk("err_last7", 16'(outQ[7].last), 16'd0);
      chk("err_next_idx", 16'(outQ[8].idx), 16'd0);
      chk("err_next_re", outQ[8].re, 16'd16384);
    end

    // Reset while idx 9 is in flight
    for (int k = 1; k < 10; k++) sendOne(16384, 0, 1'b0);
    bus.s_valid = 1'b0;
    chk("mid_valid_before", 16'(bus.m_valid), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_m_valid", 16'(bus.m_valid), 16'd0);
    chk("mid_s_ready", 16'(bus.s_ready), 16'd1);
    chk("mid_m_idx", 16'(bus.m_idx), 16'd0);
    tick();
    tick();
    rst_n = 1'b1;
    outQ.delete();
    for (int k = 0; k < 16; k++) sendOne(16384, 0, k == 15);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (5) tick();
    chk("post_count", 16'(outQ.size()), 16'd16);
    for (int k = 0; k < 16 && k < outQ.size(); k++) begin
      model(k, 16384, 0, er, ei, es);
      chk($sformatf("post_idx_%0d", k), 16'(outQ[k].idx), 16'(k));
      chk($sformatf("post_re_%0d", k), outQ[k].re, 16'(er));
      chk($sformatf("post_im_%0d", k), outQ[k].im, 16'(ei));
    end
    if (outQ.size() == 16) begin
      chk("post_re5", outQ[5].re, 16'd15137);
      chk("post_im5", outQ[5].im, 16'd6270);
      chk("post_last15", 16'(outQ[15].last), 16'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
